sequence_gen: RTL and testbench

SEQUENCE_GEN -- requirements
Module: sequence_gen

---
 rtl/sequence_gen_if.sv | 44 ++++
 rtl/sequence_gen.sv | 145 ++++++++++++++
 tb/tb_sequence_gen.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_gen_if.sv
// ============================================================================
// Module      : sequence_gen_if
// Description : Control and strobe/data bundle between the sequence
//               generator and its consumer (memory load stage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sequence_gen_if;
    logic       start;
    logic       abort;
    logic       hold;
    logic       load;
    logic [3:0] data_out;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    // Generator side: takes run control, produces the strobed sequence
    modport master (
        input  start,
        input  abort,
        input  hold,
        output load,
        output data_out,
        output step_idx,
        output busy,
        output done
    );

    // Consumer side: issues run control, receives the strobed sequence
    modport slave (
        output start,
        output abort,
        output hold,
        input  load,
        input  data_out,
        input  step_idx,
        input  busy,
        input  done
    );
endinterface

`default_nettype wire

// File: rtl/sequence_gen.sv
// ============================================================================
// Module      : sequence_gen
// Description : Emits SEQ_LEN values of a 4-bit LFSR as one-cycle load
//               strobes separated by GAP_CYCLES idle cycles (stretchable
//               by hold), with abort, done pulse and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_gen #(
    parameter int         SEQ_LEN    = 8,
    parameter int         GAP_CYCLES = 4,
    parameter logic [3:0] SEED       = 4'b1001
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sequence_gen_if.master bus
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [3:0] SEED_INIT = (SEED == 4'b0000) ? 4'b0001 : SEED;
    localparam logic [3:0] LAST_STEP = 4'(SEQ_LEN - 1);
    localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] lfsr, lfsr_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic [3:0] step, step_nxt;
    logic       load, load_nxt;
    logic       busy, busy_nxt;
    logic       done, done_nxt;
    logic [3:0] data_out, data_nxt;
    logic [3:0] step_idx, idx_nxt;
    logic [3:0] lfsr_adv;

    assign lfsr_adv = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so that every port is driven straight from a flop
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        gap_nxt   = gap_cnt;
        step_nxt  = step;
        load_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        data_nxt  = data_out;
        idx_nxt   = step_idx;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = EMIT;
                    lfsr_nxt  = SEED_INIT;
                    step_nxt  = 4'd0;
                    load_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    data_nxt  = SEED_INIT;
                    idx_nxt   = 4'd0;
                end
            end
            EMIT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    lfsr_nxt = lfsr_adv;
                    if (step == LAST_STEP) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_INIT;
                        step_nxt  = step + 4'd1;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    busy_nxt = 1'b1;
                    if (!bus.hold) begin
                        if (gap_cnt == 4'd1) begin
                            state_nxt = EMIT;
                            gap_nxt   = 4'd0;
                            load_nxt  = 1'b1;
                            data_nxt  = lfsr;
                            idx_nxt   = step;
                        end else begin
                            gap_nxt = gap_cnt - 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED_INIT;
            gap_cnt  <= 4'd0;
            step     <= 4'd0;
            load     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= 4'd0;
            step_idx <= 4'd0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            gap_cnt  <= gap_nxt;
            step     <= step_nxt;
            load     <= load_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            data_out <= data_nxt;
            step_idx <= idx_nxt;
        end
    end

    assign bus.load     = load;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.data_out = data_out;
    assign bus.step_idx = step_idx;

endmodule

`default_nettype wire

// File: tb/tb_sequence_gen.sv
// ============================================================================
// Module      : tb_sequence_gen
// Description : Directed self-checking bench for sequence_gen. Observed
//               word per cycle is {load, busy, done, step_idx, data_out}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_gen;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [10:0] got;
    logic [10:0] expv;
    logic [3:0]  seqv [8] = '{4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

    sequence_gen_if bus ();
    sequence_gen_if bus1 ();

    sequence_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sequence_gen #(
        .SEQ_LEN    (1),
        .GAP_CYCLES (4),
        .SEED       (4'b0000)
    ) u_one (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_main got=%h exp=%h", got, 11'h000);
        end
        got = {bus1.load, bus1.busy, bus1.done, bus1.step_idx, bus1.data_out};
        vectors++;
        if (got !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_single got=%h exp=%h", got, 11'h000);
        end
        rst = 1'b0;
        tick();
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_idle got=%h exp=%h", got, 11'h000);
        end
    endtask

    task automatic test_full_run;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            expv = {3'b110, 4'(k), seqv[k]};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL run_emit k=%0d got=%h exp=%h", k, got, expv);
            end
            if (k < 7) begin
                for (int g = 0; g < 4; g++) begin
                    tick();
                    got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
                    expv = {3'b010, 4'(k), seqv[k]};
                    vectors++;
                    if (got !== expv) begin
                        miscompares++;
                        $display("FAIL run_gap k=%0d g=%0d got=%h exp=%h", k, g, got, expv);
                    end
                end
                tick();
            end else begin
                tick();
                got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
                expv = {3'b001, 4'd7, 4'h7};
                vectors++;
                if (got !== expv) begin
                    miscompares++;
                    $display("FAIL run_done got=%h exp=%h", got, expv);
                end
                tick();
                got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
                expv = {3'b000, 4'd7, 4'h7};
                vectors++;
                if (got !== expv) begin
                    miscompares++;
                    $display("FAIL run_idle got=%h exp=%h", got, expv);
                end
            end
        end
    endtask

    task automatic test_hold_abort;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b110, 4'd0, 4'h9}) begin
            miscompares++;
            $display("FAIL hold_first got=%h exp=%h", got, {3'b110, 4'd0, 4'h9});
        end
        // seven non-strobe cycles: one plain, three held, three counting
        for (int c = 0; c < 7; c++) begin
            tick();
            bus.hold = (c < 3);
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== {3'b010, 4'd0, 4'h9}) begin
                miscompares++;
                $display("FAIL hold_gap c=%0d got=%h exp=%h", c, got, {3'b010, 4'd0, 4'h9});
            end
        end
        tick();
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b110, 4'd1, 4'h3}) begin
            miscompares++;
            $display("FAIL hold_second got=%h exp=%h", got, {3'b110, 4'd1, 4'h3});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== {3'b010, 4'd1, 4'h3}) begin
                miscompares++;
                $display("FAIL abort_gap c=%0d got=%h exp=%h", c, got, {3'b010, 4'd1, 4'h3});
            end
        end
        bus.abort = 1'b1;
        tick();
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b000, 4'd1, 4'h3}) begin
            miscompares++;
            $display("FAIL abort_idle got=%h exp=%h", got, {3'b000, 4'd1, 4'h3});
        end
        // abort and start together in IDLE: abort wins
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== {3'b000, 4'd1, 4'h3}) begin
                miscompares++;
                $display("FAIL abort_stay c=%0d got=%h exp=%h", c, got, {3'b000, 4'd1, 4'h3});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        bus.start = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
                expv = {3'b110, 4'(k), seqv[k]};
                vectors++;
                if (got !== expv) begin
                    miscompares++;
                    $display("FAIL b2b_emit r=%0d k=%0d got=%h exp=%h", r, k, got, expv);
                end
                if (k < 7) begin
                    for (int g = 0; g < 4; g++) begin
                        tick();
                        got  = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
                        expv = {3'b010, 4'(k), seqv[k]};
                        vectors++;
                        if (got !== expv) begin
                            miscompares++;
                            $display("FAIL b2b_gap r=%0d k=%0d got=%h exp=%h", r, k, got, expv);
                        end
                    end
                    tick();
                end
            end
            tick();
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== {3'b001, 4'd7, 4'h7}) begin
                miscompares++;
                $display("FAIL b2b_done r=%0d got=%h exp=%h", r, got, {3'b001, 4'd7, 4'h7});
            end
            if (r == 1) bus.start = 1'b0;
            tick();
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== {3'b000, 4'd7, 4'h7}) begin
                miscompares++;
                $display("FAIL b2b_idle r=%0d got=%h exp=%h", r, got, {3'b000, 4'd7, 4'h7});
            end
            tick();
        end
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b000, 4'd7, 4'h7}) begin
            miscompares++;
            $display("FAIL b2b_stop got=%h exp=%h", got, {3'b000, 4'd7, 4'h7});
        end
    endtask

    task automatic test_async_reset;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b010, 4'd0, 4'h9}) begin
            miscompares++;
            $display("FAIL arst_pre got=%h exp=%h", got, {3'b010, 4'd0, 4'h9});
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== 11'h000) begin
            miscompares++;
            $display("FAIL arst_now got=%h exp=%h", got, 11'h000);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
            vectors++;
            if (got !== 11'h000) begin
                miscompares++;
                $display("FAIL arst_quiet c=%0d got=%h exp=%h", c, got, 11'h000);
            end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b110, 4'd0, 4'h9}) begin
            miscompares++;
            $display("FAIL arst_restart got=%h exp=%h", got, {3'b110, 4'd0, 4'h9});
        end
        tick();
        got = {bus.load, bus.busy, bus.done, bus.step_idx, bus.data_out};
        vectors++;
        if (got !== {3'b010, 4'd0, 4'h9}) begin
            miscompares++;
            $display("FAIL arst_gap got=%h exp=%h", got, {3'b010, 4'd0, 4'h9});
        end
    endtask

    task automatic test_single;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        got = {bus1.load, bus1.busy, bus1.done, bus1.step_idx, bus1.data_out};
        vectors++;
        if (got !== {3'b110, 4'd0, 4'h1}) begin
            miscompares++;
            $display("FAIL single_emit got=%h exp=%h", got, {3'b110, 4'd0, 4'h1});
        end
        tick();
        got = {bus1.load, bus1.busy, bus1.done, bus1.step_idx, bus1.data_out};
        vectors++;
        if (got !== {3'b001, 4'd0, 4'h1}) begin
            miscompares++;
            $display("FAIL single_done got=%h exp=%h", got, {3'b001, 4'd0, 4'h1});
        end
        tick();
        got = {bus1.load, bus1.busy, bus1.done, bus1.step_idx, bus1.data_out};
        vectors++;
        if (got !== {3'b000, 4'd0, 4'h1}) begin
            miscompares++;
            $display("FAIL single_idle got=%h exp=%h", got, {3'b000, 4'd0, 4'h1});
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.hold   = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus1.hold  = 1'b0;
        test_reset();
        test_full_run();
        test_hold_abort();
        test_back_to_back();
        test_async_reset();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
